data_bus_bridge: RTL and testbench
==================================

# data_bus_bridge

Sits between the core's load/store path and the system data bus. Converts a single-cycle core memory access (we/addr/wdata/size/sign) into a valid/ready request plus response-valid transaction, and holds the core with a stall while the bus is busy. Handles byte-lane steering, write strobes, load sign/zero extension, misalignment faults and response timeout. One outstanding transaction at a time.

## Interface
Parameters:
- DATA_WIDTH, 32, core and bus data/address width (only 32 supported)
- TIMEOUT_CYCLES, 255, cycles waited for bus_rvalid before a fault is raised (1..65535)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- core_req  in  1  core requests a load or store this cycle
- core_we  in  1  1 = store, 0 = load
- core_addr  in  32  byte address
- core_wdata  in  32  store data, right-aligned
- core_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- core_sign  in  1  1 = sign-extend load, 0 = zero-extend
- core_stall  out  1  core must hold PC and request fields stable
- core_rdata  out  32  extended load data, valid in DONE
- core_fault  out  1  one-cycle pulse: misaligned, illegal size, bus_err or timeout
- bus_valid  out  1  request valid
- bus_ready  in  1  bus accepts request
- bus_we  out  1  request is write
- bus_addr  out  32  word-aligned address (core_addr with [1:0] = 0)
- bus_wstrb  out  4  byte-enable; 0000 for reads
- bus_wdata  out  32  lane-replicated store data
- bus_rvalid  in  1  response (read data or write ack) valid
- bus_rdata  in  32  read data, full word
- bus_err  in  1  response error, qualified by bus_rvalid

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: if core_req and access legal -> latch we/addr/size/sign/steered wdata/strobe, go REQ. If core_req and illegal -> pulse core_fault, stay IDLE, no bus activity, core_stall low.
- Illegal: size 11; half with addr[0]=1; word with addr[1:0]!=00.
- REQ: bus_valid=1 with latched fields held stable; on bus_ready -> RESP.
- RESP: count cycles; on bus_rvalid -> capture and extend data, core_fault=bus_err, go DONE. If count reaches TIMEOUT_CYCLES with no rvalid -> core_fault=1, core_rdata=0, go DONE. bus_rvalid outside RESP is ignored.
- DONE: core_stall=0 for exactly one cycle; unconditionally -> IDLE.
- core_stall = (IDLE and core_req and legal) or REQ or RESP.
- Stores: byte -> wdata {4{b}}, wstrb 0001<<addr[1:0]; half -> {2{h}}, 0011<<addr[1:0]; word -> wdata, 1111.
- Loads: byte selected by addr[1:0], half by addr[1]; extended per core_sign to 32 bits. Stores return core_rdata=0.
- On bus_err, core_rdata=0.

## Timing
- Reset (async, immediate): state IDLE, counter 0; core_stall 0, core_rdata 0, core_fault 0, bus_valid 0, bus_we 0, bus_addr 0, bus_wstrb 0, bus_wdata 0.
- Reset mid-transaction aborts it; bus_valid drops in the reset cycle, no response is awaited afterwards.
- All bus_* outputs and core_rdata/core_fault are registered. core_stall is combinational from state and the IDLE request decode.
- Zero-wait bus (bus_ready in first REQ cycle, bus_rvalid next cycle): request in cycle 0, REQ cycle 1, RESP cycle 2, DONE cycle 3 -> 3 stall cycles, core_rdata valid in cycle 3.
- Each bus_ready wait cycle and each rvalid wait cycle adds one stall cycle.
- Timeout: fault asserted in DONE after exactly TIMEOUT_CYCLES RESP cycles.
- Back-to-back: a new core_req seen in the IDLE cycle after DONE starts a new transaction. There is no request issue in DONE.

## Test plan
- Word load addr 0x100, bus_rdata 0xDEADBEEF, zero-wait -> bus_addr 0x100, wstrb 0000, core_stall high cycles 0-2, core_rdata 0xDEADBEEF in cycle 3.
- Signed byte load addr 0x103, bus_rdata 0x80FF_0000 -> core_rdata 0xFFFFFF80. Unsigned -> 0x00000080. Half load addr 0x102, signed -> 0xFFFF80FF.
- Byte store 0xA5 addr 0x201 with bus_ready delayed 2 cycles -> bus_wdata 0xA5A5A5A5, wstrb 0010, bus_addr 0x200, fields stable while waiting, 5 stall cycles total.
- Word load addr 0x102 -> core_fault pulse same cycle+1, bus_valid never asserted, core_stall 0. size 11 -> same.
- TIMEOUT_CYCLES=4, no rvalid -> fault in DONE after 4 RESP cycles, core_rdata 0. bus_err with rvalid -> fault, core_rdata 0.
- Assert rst_n low while in RESP -> all outputs 0 immediately. After release, a late bus_rvalid is ignored and the next request completes normally.

Source files
------------

// File: rtl/data_bus_bridge.sv
// Core load/store to valid/ready data bus bridge: one outstanding access,
// byte-lane steering, load extension, misalignment and response-timeout faults.
module data_bus_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [DATA_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [1:0]            core_size,
  input  logic                  core_sign,
  output logic                  core_stall,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_fault,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_wstrb,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   access_legal = 1'b1;
      2'b01:   access_legal = ~lo[0];
      2'b10:   access_legal = (lo == 2'b00);
      default: access_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   store_strobe = 4'b0001 << lo;
      2'b01:   store_strobe = 4'b0011 << lo;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [1:0] size,
                                                       input logic [1:0] lo,
                                                       input logic sign,
                                                       input logic [DATA_WIDTH-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {lo, 3'b000});
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   load_extend = {{24{sign & b[7]}}, b};
      2'b01:   load_extend = {{16{sign & h[15]}}, h};
      default: load_extend = rd;
    endcase
  endfunction

  logic [1:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [1:0]            lane_q, lane_d;
  logic                  bus_valid_q, bus_valid_d;
  logic                  bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]            bus_wstrb_q, bus_wstrb_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic                  core_fault_q, core_fault_d;
  logic                  req_legal;

  assign req_legal  = access_legal(core_size, core_addr[1:0]);
  assign core_stall = ((state_q == S_IDLE) && core_req && req_legal) ||
                      (state_q == S_REQ) || (state_q == S_RESP);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    sign_d       = sign_q;
    lane_d       = lane_q;
    bus_valid_d  = bus_valid_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_wdata_d  = bus_wdata_q;
    core_rdata_d = core_rdata_q;
    core_fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          if (req_legal) begin
            size_d      = core_size;
            sign_d      = core_sign;
            lane_d      = core_addr[1:0];
            bus_valid_d = 1'b1;
            bus_we_d    = core_we;
            bus_addr_d  = {core_addr[DATA_WIDTH-1:2], 2'b00};
            bus_wstrb_d = core_we ? store_strobe(core_size, core_addr[1:0]) : 4'b0000;
            bus_wdata_d = core_we ? store_data(core_size, core_wdata) : '0;
            state_d     = S_REQ;
          end else begin
            core_fault_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        // A response on the final counted cycle still wins over the timeout.
        if (bus_rvalid) begin
          core_fault_d = bus_err;
          core_rdata_d = (bus_err || bus_we_q) ? '0
                         : load_extend(size_q, lane_q, sign_q, bus_rdata);
          state_d      = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          core_fault_d = 1'b1;
          core_rdata_d = '0;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      lane_q       <= '0;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wstrb_q  <= '0;
      bus_wdata_q  <= '0;
      core_rdata_q <= '0;
      core_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      lane_q       <= lane_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_wdata_q  <= bus_wdata_d;
      core_rdata_q <= core_rdata_d;
      core_fault_q <= core_fault_d;
    end
  end

  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_wdata  = bus_wdata_q;
  assign core_rdata = core_rdata_q;
  assign core_fault = core_fault_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: per-cycle model expectations checked on the falling
// edge, plus literal expectations for the directed transactions.
module tb_data_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, core_sign;
  logic [31:0] core_addr, core_wdata;
  logic [1:0]  core_size;
  logic        core_stall, core_fault;
  logic [31:0] core_rdata;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid, bus_err;

  int checks = 0;
  int failures = 0;

  // Model expectations for the current cycle.
  logic        e_stall, e_valid, e_we, e_fault, e_chk_rdata, e_all_zero;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wstrb;

  data_bus_bridge #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_size(core_size), .core_sign(core_sign),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_fault(core_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic m_legal(input logic [1:0] size, input logic [31:0] addr);
    int unsigned lo;
    lo = addr[1:0];
    if (size == 2'd3) return 1'b0;
    if (size == 2'd1 && (lo % 2) != 0) return 1'b0;
    if (size == 2'd2 && lo != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [1:0] size, input logic [31:0] addr);
    int unsigned lo;
    lo = addr[1:0];
    if (size == 2'd0) return 4'(1 << lo);
    if (size == 2'd1) return 4'(3 << lo);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                         input logic sign, input logic [31:0] rd);
    int unsigned lo;
    logic [31:0] v;
    lo = addr[1:0];
    if (size == 2'd0) begin
      v = (rd >> (8 * lo)) & 32'hFF;
      if (sign && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rd >> (16 * (lo / 2))) & 32'hFFFF;
      if (sign && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    check("stall", {31'd0, core_stall}, {31'd0, e_stall});
    check("bus_valid", {31'd0, bus_valid}, {31'd0, e_valid});
    check("fault", {31'd0, core_fault}, {31'd0, e_fault});
    if (e_valid) begin
      check("bus_we", {31'd0, bus_we}, {31'd0, e_we});
      check("bus_addr", bus_addr, e_addr);
      check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e_wstrb});
      if (e_we) check("bus_wdata", bus_wdata, e_wdata);
    end
    if (e_chk_rdata) check("rdata", core_rdata, e_rdata);
    if (e_all_zero) begin
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_rdata", core_rdata, 32'd0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    next_cycle();
    core_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    e_stall = 1'b0; e_valid = 1'b0; e_fault = 1'b0; e_chk_rdata = 1'b0;
  endtask

  // vdly < 0 means no response ever arrives (timeout path).
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sign,
                         input int rdly, input int vdly,
                         input logic [31:0] rdata, input logic err,
                         input logic [31:0] lit_addr, input logic [3:0] lit_wstrb,
                         input logic [31:0] lit_wdata, input logic [31:0] lit_rdata,
                         input int lit_stalls, input logic lit_fault);
    int stalls;
    int nresp;
    logic to;
    to = (vdly < 0);
    stalls = 0;
    next_cycle();
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    core_size = size; core_sign = sign; bus_ready = 1'b0; bus_rvalid = 1'b0;
    e_all_zero = 1'b0; e_stall = 1'b1; e_valid = 1'b0; e_fault = 1'b0; e_chk_rdata = 1'b0;
    @(negedge clk); stalls += int'(core_stall);
    for (int i = 0; i <= rdly; i++) begin
      next_cycle();
      bus_ready = (i == rdly);
      e_valid = 1'b1; e_we = we;
      e_addr = addr & 32'hFFFF_FFFC;
      e_wstrb = we ? m_wstrb(size, addr) : 4'h0;
      e_wdata = m_wdata(size, wdata);
      @(negedge clk); stalls += int'(core_stall);
      if (i == 0) begin
        check("lit_bus_addr", bus_addr, lit_addr);
        check("lit_bus_wstrb", {28'd0, bus_wstrb}, {28'd0, lit_wstrb});
        if (we) check("lit_bus_wdata", bus_wdata, lit_wdata);
      end
    end
    nresp = to ? TO : vdly + 1;
    for (int j = 0; j < nresp; j++) begin
      next_cycle();
      bus_ready = 1'b0; e_valid = 1'b0;
      bus_rvalid = !to && (j == vdly);
      bus_rdata = rdata; bus_err = err;
      @(negedge clk); stalls += int'(core_stall);
    end
    next_cycle();
    bus_rvalid = 1'b0; bus_err = 1'b0; core_req = 1'b0;
    e_stall = 1'b0; e_fault = err | to; e_chk_rdata = 1'b1;
    e_rdata = (err || to || we) ? 32'd0 : m_load(size, addr, sign, rdata);
    @(negedge clk); stalls += int'(core_stall);
    check("lit_rdata", core_rdata, lit_rdata);
    check("lit_fault", {31'd0, core_fault}, {31'd0, lit_fault});
    check("lit_stalls", stalls, lit_stalls);
  endtask

  task automatic illegal_txn(input logic [31:0] addr, input logic [1:0] size);
    next_cycle();
    core_req = 1'b1; core_we = 1'b0; core_addr = addr; core_size = size; core_sign = 1'b0;
    e_stall = m_legal(size, addr); e_valid = 1'b0; e_fault = 1'b0; e_chk_rdata = 1'b0;
    next_cycle();
    core_req = 1'b0; e_fault = 1'b1;
    @(negedge clk);
    check("lit_illegal_fault", {31'd0, core_fault}, 32'd1);
    next_cycle();
    e_fault = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    core_size = 2'd0; core_sign = 1'b0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    e_stall = 1'b0; e_valid = 1'b0; e_we = 1'b0; e_fault = 1'b0;
    e_chk_rdata = 1'b0; e_all_zero = 1'b1;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_wstrb = '0;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    idle_cycle();

    // Loads, zero-wait bus.
    run_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0,
            32'h100, 4'h0, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    run_txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 0, 0, 32'h80FF_0000, 1'b0,
            32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 3, 1'b0);
    run_txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 0, 0, 32'h80FF_0000, 1'b0,
            32'h100, 4'h0, 32'h0, 32'h0000_0080, 3, 1'b0);
    run_txn(1'b0, 32'h102, 32'h0, 2'd1, 1'b1, 0, 0, 32'h80FF_0000, 1'b0,
            32'h100, 4'h0, 32'h0, 32'hFFFF_80FF, 3, 1'b0);
    run_txn(1'b0, 32'h100, 32'h0, 2'd1, 1'b0, 1, 2, 32'h1234_F00D, 1'b0,
            32'h100, 4'h0, 32'h0, 32'h0000_F00D, 6, 1'b0);
    idle_cycle();

    // Stores with varied wait states.
    run_txn(1'b1, 32'h201, 32'h1234_56A5, 2'd0, 1'b0, 2, 0, 32'h0, 1'b0,
            32'h200, 4'b0010, 32'hA5A5_A5A5, 32'h0, 5, 1'b0);
    run_txn(1'b1, 32'h302, 32'h0000_BEEF, 2'd1, 1'b0, 0, 1, 32'h0, 1'b0,
            32'h300, 4'b1100, 32'hBEEF_BEEF, 32'h0, 4, 1'b0);
    run_txn(1'b1, 32'h40C, 32'h1122_3344, 2'd2, 1'b0, 0, 0, 32'h0, 1'b0,
            32'h40C, 4'b1111, 32'h1122_3344, 32'h0, 3, 1'b0);

    // Illegal accesses: fault pulse, no bus activity.
    illegal_txn(32'h102, 2'd2);
    illegal_txn(32'h100, 2'd3);
    illegal_txn(32'h101, 2'd1);

    // Timeout and bus error.
    run_txn(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, 0, -1, 32'h0, 1'b0,
            32'h500, 4'h0, 32'h0, 32'h0, 6, 1'b1);
    run_txn(1'b0, 32'h600, 32'h0, 2'd2, 1'b0, 0, 0, 32'hFFFF_FFFF, 1'b1,
            32'h600, 4'h0, 32'h0, 32'h0, 3, 1'b1);
    idle_cycle();

    // Reset while waiting for a response.
    next_cycle();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h700; core_size = 2'd2;
    e_stall = 1'b1; e_valid = 1'b0; e_chk_rdata = 1'b0;
    next_cycle();
    bus_ready = 1'b1; e_valid = 1'b1; e_we = 1'b0; e_addr = 32'h700; e_wstrb = 4'h0;
    next_cycle();
    bus_ready = 1'b0; e_valid = 1'b0;
    next_cycle();
    #1;
    core_req = 1'b0;
    e_stall = 1'b0; e_valid = 1'b0; e_fault = 1'b0; e_all_zero = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus_valid}, 32'd0);
    check("async_rst_stall", {31'd0, core_stall}, 32'd0);
    check("async_rst_addr", bus_addr, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h0000_0055; bus_err = 1'b1;
    next_cycle();
    bus_rvalid = 1'b0; bus_err = 1'b0;
    run_txn(1'b0, 32'h701, 32'h0, 2'd0, 1'b0, 0, 0, 32'h0000_AB00, 1'b0,
            32'h700, 4'h0, 32'h0, 32'h0000_00AB, 3, 1'b0);
    idle_cycle();
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
